btn_event_decoder: RTL and testbench



---
 rtl/btn_event_decoder_pkg.sv | 26 ++
 rtl/level_edge_detect.sv | 24 ++
 rtl/btn_event_decoder.sv | 137 +++++++++++++
 tb/tb_btn_event_decoder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_event_decoder_pkg.sv
// Shared definitions for the button event decoder: FSM encoding, counter width
// and the millisecond-to-cycle scaling used by every timed threshold.
package btn_event_decoder_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'b000,
      PRESS1 = 3'b001,
      WAIT2  = 3'b010,
      PRESS2 = 3'b011,
      HOLD   = 3'b100
   } state_t;

   localparam int CNT_W = 24;

   // Hardware builds count real milliseconds; simulation shrinks each ms to FREQUENCY cycles.
`ifdef FPGA
   localparam int CPM_SCALE = 1000;
`else
   localparam int CPM_SCALE = 1;
`endif

   function automatic int cycles_per_ms(input int freq_mhz);
      return freq_mhz * CPM_SCALE;
   endfunction

endpackage

// File: rtl/level_edge_detect.sv
// One-register edge detector: flags the cycle where a synchronous level
// changes relative to its value on the previous clock.
module level_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic level,
   output logic rise,
   output logic fall
);

   logic level_d_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_d_reg <= 1'b0;
      end else begin
         level_d_reg <= level;
      end
   end

   assign rise = level & ~level_d_reg;
   assign fall = ~level & level_d_reg;

endmodule

// File: rtl/btn_event_decoder.sv
// Classifies a debounced button level into one-cycle short, double, long and
// auto-repeat pulses, plus a holding level while a long press is sustained.
module btn_event_decoder
   import btn_event_decoder_pkg::*;
#(
   parameter int FREQUENCY = 5,
   parameter int LONG_MS   = 100,
   parameter int DCLICK_MS = 40,
   parameter int REPEAT_MS = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_level,
   output logic short_press,
   output logic double_press,
   output logic long_press,
   output logic repeat_press,
   output logic holding
);

   localparam int CPM = cycles_per_ms(FREQUENCY);

   // Terminal counts are stored as N-1 so the compare happens on the edge that completes N cycles.
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_MS * CPM - 1);
   localparam logic [CNT_W-1:0] DCLK_LAST = CNT_W'(DCLICK_MS * CPM - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_MS * CPM - 1);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             short_reg, short_next;
   logic             double_reg, double_next;
   logic             long_reg, long_next;
   logic             repeat_reg, repeat_next;
   logic             holding_reg, holding_next;
   logic             rise, fall;

   level_edge_detect u_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .level (btn_level),
      .rise  (rise),
      .fall  (fall)
   );

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      short_next   = 1'b0;
      double_next  = 1'b0;
      long_next    = 1'b0;
      repeat_next  = 1'b0;
      holding_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (rise) begin
               state_next = PRESS1;
               cnt_next   = '0;
            end
         end
         PRESS1: begin
            // Checking release first lets a release on the threshold edge win over long.
            if (!btn_level) begin
               state_next = WAIT2;
               cnt_next   = '0;
            end else if (cnt_reg == LONG_LAST) begin
               state_next = HOLD;
               cnt_next   = '0;
               long_next  = 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         WAIT2: begin
            if (rise) begin
               state_next  = PRESS2;
               cnt_next    = '0;
               double_next = 1'b1;
            end else if (cnt_reg == DCLK_LAST) begin
               state_next = IDLE;
               cnt_next   = '0;
               short_next = 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         PRESS2: begin
            if (fall) begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         end
         HOLD: begin
            holding_next = 1'b1;
            if (!btn_level) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (cnt_reg == REP_LAST) begin
               cnt_next    = '0;
               repeat_next = 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         short_reg   <= 1'b0;
         double_reg  <= 1'b0;
         long_reg    <= 1'b0;
         repeat_reg  <= 1'b0;
         holding_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         short_reg   <= short_next;
         double_reg  <= double_next;
         long_reg    <= long_next;
         repeat_reg  <= repeat_next;
         holding_reg <= holding_next;
      end
   end

   assign short_press  = short_reg;
   assign double_press = double_reg;
   assign long_press   = long_reg;
   assign repeat_press = repeat_reg;
   assign holding      = holding_reg;

endmodule

// File: tb/tb_btn_event_decoder.sv
// Directed bench for btn_event_decoder: expected pulses are queued with their
// clock-edge index when stimulus is applied and matched as the DUT emits them.
module tb_btn_event_decoder;
   import btn_event_decoder_pkg::*;

   localparam int K_SHORT  = 0;
   localparam int K_DOUBLE = 1;
   localparam int K_LONG   = 2;
   localparam int K_REPEAT = 3;

   typedef struct {
      int kind;
      int cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic btn_drv = 1'b0;
   logic raw_btn = 1'b0;
   logic raw_q = 1'b0;
   logic deb_level = 1'b0;
   logic use_deb = 1'b0;
   logic btn_level;
   logic short_press, double_press, long_press, repeat_press, holding;

   int   edge_cnt = 0;
   int   stable_cnt = 0;
   int   hold_lo = 1;
   int   hold_hi = 0;
   int   checks = 0;
   int   errors = 0;
   int   r0;
   exp_t exp_q[$];
   exp_t cur;
   logic [3:0] pulses;

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Small stand-in debouncer: follows raw_btn only after 8 stable cycles.
   always @(posedge clk) begin
      if (raw_btn != raw_q) begin
         raw_q      <= raw_btn;
         stable_cnt <= 0;
      end else if (stable_cnt < 8) begin
         stable_cnt <= stable_cnt + 1;
      end else begin
         deb_level <= raw_q;
      end
   end

   assign btn_level = use_deb ? deb_level : btn_drv;

   btn_event_decoder dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn_level    (btn_level),
      .short_press  (short_press),
      .double_press (double_press),
      .long_press   (long_press),
      .repeat_press (repeat_press),
      .holding      (holding)
   );

   task automatic check_bit(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic check_int(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic push(input int kind, input int cyc);
      exp_t e;
      e.kind = kind;
      e.cyc  = cyc;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic lvl, input int n);
      btn_drv = lvl;
      repeat (n) @(negedge clk);
   endtask

   task automatic check_all_low(input string tag);
      check_bit({tag, "_short"}, short_press, 1'b0);
      check_bit({tag, "_double"}, double_press, 1'b0);
      check_bit({tag, "_long"}, long_press, 1'b0);
      check_bit({tag, "_repeat"}, repeat_press, 1'b0);
      check_bit({tag, "_holding"}, holding, 1'b0);
   endtask

   // Output monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      pulses = {repeat_press, long_press, double_press, short_press};
      check_bit("one_hot", logic'($countones(pulses) <= 1), 1'b1);
      check_bit("holding", holding, logic'(edge_cnt >= hold_lo && edge_cnt <= hold_hi));
      for (int k = 0; k < 4; k++) begin
         if (pulses[k]) begin
            $display("edge %0d: pulse kind %0d observed", edge_cnt, k);
            checks++;
            assert (exp_q.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_pulse: got kind %0d at edge %0d, expected none", k, edge_cnt);
            end
            if (exp_q.size() != 0) begin
               cur = exp_q.pop_front();
               check_int("pulse_kind", k, cur.kind);
               if (cur.cyc >= 0) check_int("pulse_edge", edge_cnt, cur.cyc);
            end
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      check_all_low("reset");
      check_int("reset_state", int'(dut.state_reg), int'(IDLE));
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Short press: 50 high, fall captured at R+50, short 200 edges later.
      r0 = edge_cnt + 1;
      push(K_SHORT, r0 + 250);
      drive(1'b1, 50);
      drive(1'b0, 300);

      // Double press: second rise at R+150.
      r0 = edge_cnt + 1;
      push(K_DOUBLE, r0 + 150);
      drive(1'b1, 50);
      drive(1'b0, 100);
      drive(1'b1, 50);
      drive(1'b0, 300);

      // Long press with auto-repeat, held 800 cycles.
      r0 = edge_cnt + 1;
      push(K_LONG, r0 + 500);
      push(K_REPEAT, r0 + 600);
      push(K_REPEAT, r0 + 700);
      hold_lo = r0 + 501;
      hold_hi = r0 + 800;
      drive(1'b1, 800);
      drive(1'b0, 300);

      // 499 cycles high stays below the long threshold.
      r0 = edge_cnt + 1;
      push(K_SHORT, r0 + 699);
      drive(1'b1, 499);
      drive(1'b0, 300);

      // Release seen on the threshold edge itself: still short.
      r0 = edge_cnt + 1;
      push(K_SHORT, r0 + 700);
      drive(1'b1, 500);
      drive(1'b0, 300);

      // Second rise exactly on the double-click timeout edge: double only.
      r0 = edge_cnt + 1;
      push(K_DOUBLE, r0 + 250);
      drive(1'b1, 50);
      drive(1'b0, 200);
      drive(1'b1, 30);
      drive(1'b0, 300);

      // Reset while in HOLD at edge R+550, button released during reset.
      r0 = edge_cnt + 1;
      push(K_LONG, r0 + 500);
      hold_lo = r0 + 501;
      hold_hi = r0 + 550;
      drive(1'b1, 551);
      #2 rst_n = 1'b0;
      #1;
      check_all_low("mid_reset");
      check_int("mid_reset_state", int'(dut.state_reg), int'(IDLE));
      check_int("mid_reset_cnt", int'(dut.cnt_reg), 0);
      @(negedge clk);
      btn_drv = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 400);

      // Chattering raw button through the stand-in debouncer: one short press.
      use_deb = 1'b1;
      push(K_SHORT, -1);
      for (int i = 0; i < 5; i++) begin
         raw_btn = ~raw_btn;
         repeat (2) @(negedge clk);
      end
      raw_btn = 1'b1;
      repeat (60) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         raw_btn = ~raw_btn;
         repeat (2) @(negedge clk);
      end
      raw_btn = 1'b0;
      repeat (400) @(negedge clk);

      check_int("pending_expected_pulses", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
